prog_clk_div: RTL

- Runtime-programmable clock divider; generates clk_out = clk / N with 50% duty cycle for both even and odd N.
- Parametrised successor of the fixed divide-by-3 50% block, generalised to any N in 2..2^W-1.
- Adds enable, a divisor-load handshake with glitch-free retiming at period boundaries, a period tick and error reporting.
- Sits in the clock-generation area and feeds slow-domain enables and clocks.

---
 rtl/freq_div_pkg.sv | 29 ++
 rtl/neg_capture.sv | 25 ++
 rtl/prog_clk_div.sv | 136 +++++++++++++
 3 files changed

// File: rtl/freq_div_pkg.sv
// -----------------------------------------------------------------------------
// freq_div_pkg
// Shared constants and helpers for the programmable 50% clock divider.
//   MIN_DIV     : smallest divisor the divider can produce (divide-by-2).
//   div_mode_e  : output path select, taken from the divisor LSB.
//   half_ceil() : number of posedge phases the output is held high, ceil(N/2).
//   div_legal() : elaboration-time range check for a divisor in a W-bit field.
// -----------------------------------------------------------------------------
package freq_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Even divisors use the posedge phase directly; odd divisors AND it with a
  // half-cycle delayed copy to trim the high time by exactly half a clk period.
  typedef enum logic {
    MODE_EVEN = 1'b0,
    MODE_ODD  = 1'b1
  } div_mode_e;

  function automatic int unsigned half_ceil(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  // True when n fits in w bits and is at least MIN_DIV.
  function automatic bit div_legal(input int unsigned n, input int unsigned w);
    return (n >= MIN_DIV) && ((n >> w) == 0);
  endfunction

endpackage

// File: rtl/neg_capture.sv
// -----------------------------------------------------------------------------
// neg_capture
// Single flop clocked on the falling edge of clk, cleared asynchronously.
// Provides the half-cycle delayed phase used to build odd-divisor outputs.
//   clk : clock (falling edge active)
//   rst : asynchronous active-low reset
//   d   : data captured on negedge clk
//   q   : captured value
// -----------------------------------------------------------------------------
module neg_capture (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// -----------------------------------------------------------------------------
// prog_clk_div
// Runtime-programmable clock divider producing clk_out = clk / N with a 50%
// duty cycle for both even and odd N (2 <= N <= 2^W-1). A new divisor is
// requested with div_load, held in div_pend, and applied only at an output
// period boundary (or on the next edge while disabled) so clk_out never shows
// a runt pulse.
//   clk      : input clock; posedge drives all state, negedge only neg_capture
//   rst      : asynchronous active-low reset
//   en       : divider enable, sampled on posedge clk
//   div_in   : requested divisor N
//   div_load : one-cycle request to load div_in
//   div_ack  : one-cycle pulse on the edge the new divisor takes effect
//   div_err  : one-cycle pulse when a requested divisor is 0 or 1
//   pending  : an accepted divisor is waiting for the period boundary
//   div_cur  : divisor currently in effect
//   cnt      : phase counter, 0..div_cur-1
//   tick     : one-cycle pulse at the start of every output period
//   clk_out  : divided clock
// When en drops mid-period, clk_out falls within half a clk cycle; the high
// pulse in progress is truncated.
// -----------------------------------------------------------------------------
module prog_clk_div
  import freq_div_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_load,
  output logic         div_ack,
  output logic         div_err,
  output logic         pending,
  output logic [W-1:0] div_cur,
  output logic [W-1:0] cnt,
  output logic         tick,
  output logic         clk_out
);

  localparam bit           DEFAULT_OK    = div_legal(DEFAULT_DIV, W);
  localparam logic [W-1:0] DEFAULT_DIV_W = W'(DEFAULT_DIV);
  localparam logic [W-1:0] MIN_DIV_W     = W'(MIN_DIV);
  localparam logic [W-1:0] ONE_W         = W'(1);

  if (!DEFAULT_OK) begin : g_bad_default
    $error("prog_clk_div: DEFAULT_DIV must lie in 2..2^W-1");
  end

  logic [W-1:0] div_pend;   // accepted divisor waiting for the boundary
  logic [W-1:0] last_cnt;   // div_cur-1; div_cur >= 2 so this never underflows
  logic [W-1:0] half;       // ceil(div_cur/2), at most 2^(W-1), fits in W bits
  logic [W-1:0] cnt_next;
  logic         run_q;      // en as sampled on the previous posedge
  logic         wrap;
  logic         accept;
  logic         reject;
  logic         apply;
  logic         p_pos;
  logic         p_neg;
  div_mode_e    mode;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    last_cnt = div_cur - ONE_W;
    half     = W'(half_ceil(32'(div_cur)));
    wrap     = run_q && (cnt == last_cnt);
    accept   = div_load && (div_in >= MIN_DIV_W);
    reject   = div_load && (div_in <  MIN_DIV_W);
    // Disabled: apply on the first edge after acceptance. Running: only where
    // the current period ends, so the next period starts cleanly with new N.
    apply    = pending && (!en || wrap);

    cnt_next = cnt + ONE_W;
    // The first enabled edge after idle starts a period at phase 0 rather
    // than advancing, so tick and p_pos appear on that very edge.
    if (!en || !run_q || wrap) begin
      cnt_next = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      div_cur  <= DEFAULT_DIV_W;
      div_pend <= DEFAULT_DIV_W;
      pending  <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
      tick     <= 1'b0;
      run_q    <= 1'b0;
      p_pos    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      run_q   <= en;
      // On an apply edge cnt_next is 0, which is below any half, so using the
      // outgoing divisor's half here is harmless.
      p_pos   <= en && (cnt_next < half);
      tick    <= en && (cnt_next == '0);
      div_ack <= apply;
      div_err <= reject;

      if (apply) begin
        div_cur <= div_pend;
      end

      // A request landing on the apply edge is queued behind the one being
      // applied: div_cur takes the old div_pend while pending stays set.
      if (accept) begin
        div_pend <= div_in;
        pending  <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  neg_capture u_neg_capture (
    .clk (clk),
    .rst (rst),
    .d   (p_pos),
    .q   (p_neg)
  );

  // Mode follows the registered div_cur, so it only switches on the edge where
  // a new period starts; both mux inputs are low just before that edge, which
  // keeps the switch glitch-free.
  assign mode    = div_mode_e'(div_cur[0]);
  assign clk_out = (mode == MODE_ODD) ? (p_pos & p_neg) : p_pos;

endmodule
